cic_decim_mc: RTL
=================

// Module: cic_decim_mc
// PURPOSE
//  Multichannel CIC decimator with parametrised stage count and runtime power-of-two decimation.
//  Successor of the single-channel fixed CIC; sits between the ADC front end and the FIR compensator.
//  Time-multiplexed: one integrator/comb datapath shared by NCH channels, per-channel state in arrays.
//  Full-precision internal arithmetic; gain-normalised WOUT output, truncate or round-half-up.
// PARAMETERS
//  WIN     16  input sample width (signed two's complement)
//  WOUT    16  output sample width
//  N       3   number of integrator and comb stages
//  M       1   differential delay (1 or 2)
//  RLOG_MAX 6  max log2(R); RMAX = 64
//  NCH     2   channel count (>=1)
//  WG      derived = N*(RLOG_MAX+clog2(M)); full width WF = WIN+WG
// PORTS
//  clk          in   1            clock, all logic on rising edge
//  rst          in   1            reset, asynchronous, active-low
//  i_data       in   WIN          input sample
//  i_ch         in   clog2(NCH)   channel tag of i_data
//  val_in       in   1            i_data/i_ch valid this cycle
//  cfg_we       in   1            load cfg_rlog/cfg_round; flushes all state
//  cfg_rlog     in   clog2(RLOG_MAX+1)  log2(R), legal 1..RLOG_MAX
//  cfg_round    in   1            1 = round-half-up + saturate, 0 = truncate
//  val_out      out  1            output valid, single-cycle pulse
//  o_ch         out  clog2(NCH)   channel tag of output
//  o_data_trunc out  WOUT         normalised output
//  o_data_full  out  WF           full-precision comb output
// BEHAVIOUR
//  - Reset (rst=0): val_out=0, o_ch=0, o_data_trunc=0, o_data_full=0; all integrators, comb
//    delays, per-channel phase counters cleared; rlog=RLOG_MAX, round=0. Async assert, sync use.
//  - val_in accepted every cycle, any channel order; i_ch>=NCH ignored (no state change).
//  - Integrators: N pipelined stages, stage k acc[ch] <= acc[ch] + stage(k-1) out, WF-bit wrap.
//    A channel's samples retain order; back-to-back same-channel samples need correct forwarding.
//  - Decimation: per-channel phase counter 0..R-1, R=2^rlog; increments per accepted sample,
//    and on wrap (count==R-1) the stage-N integrator output enters the comb pipeline.
//  - Combs: N pipelined stages, y=x-x[ch] delayed M decimated samples, WF-bit wrap.
//  - Normalise: shift = N*(rlog+clog2(M)); trunc = full>>>shift low WOUT bits of
//    [WIN+shift-1 -: WOUT] (WOUT<=WIN: keep MSBs). Round: add 2^(shift-1) before shift,
//    then saturate to [-2^(WOUT-1), 2^(WOUT-1)-1].
//  - Latency: val_in of decimating sample at edge t -> val_out at edge t+2N+1, o_ch = i_ch.
//  - cfg_we: same-cycle val_in dropped; next cycle all state flushed as reset (outputs 0),
//    new rlog/round active from the following sample. cfg_rlog outside 1..RLOG_MAX: clamp.
//  - Mid-operation rst: in-flight pipeline discarded, no val_out until R fresh samples.
// STRUCTURE
//  - cic_defs.vh: clog2 function, WG/WF derivation macros, MODE_INT/MODE_COMB constants.
//  - Sub-module cic_stage (MODE=INT|COMB, W, NCH, M): one pipelined stage with per-channel
//    state array; instantiated N times each in generate loops. Top holds counters and normaliser.
// TESTING  (N=3, M=1, NCH=2, WIN=WOUT=16 unless stated)
//  - DC: ch0 constant 1000, rlog=2 (R=4) -> settled o_data_full=64000, o_data_trunc=1000,
//    val_out every 4th ch0 sample, 7 cycles after decimating input.
//  - Rounding: ch0 impulse 30 then zeros, R=4: first full=300 at sample idx 3 is not an
//    impulse tap; check full seq (30*h[3],30*h[7])=(300,180) -> trunc (4,2), round (5,3).
//  - Interleave: ch0=1000, ch1=-500 alternate each cycle -> outputs tagged 0/1 alternately,
//    settled 1000 / -500, no cross-channel contamination; i_ch=2 samples ignored (NCH=2 -> 1-bit tag: skip).
//  - Extremes: DC +32767 and -32768 with cfg_round=1 -> outputs 32767 / -32768, no wrap.
//  - Reconfig: cfg_we with rlog=3 during traffic -> outputs 0 / none until 8 samples, DC 100 -> 100.
//  - Async reset mid-stream: rst low between edges -> val_out/o_data 0 immediately; after
//    release first val_out only after R new samples, value matches clean-start model.

Source files
------------

// File: rtl/cic_decim_mc_pkg.sv
// Shared constants and elaboration helpers for the multichannel CIC decimator.
package cic_decim_mc_pkg;
  localparam int MODE_INT  = 0;
  localparam int MODE_COMB = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Bit growth of an N-stage CIC at the largest decimation ratio.
  function automatic int cic_wg(input int n, input int rlog_max, input int m);
    return n * (rlog_max + clog2(m));
  endfunction
endpackage

// File: rtl/cic_decim_mc_stage.sv
// One pipelined integrator or comb stage, time-shared across channels
// with per-channel state held in a small array.
module cic_decim_mc_stage
  import cic_decim_mc_pkg::*;
#(
  parameter int MODE = MODE_INT,
  parameter int W    = 34,
  parameter int NCH  = 2,
  parameter int M    = 1,
  parameter int CHW  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           in_vld,
  input  logic [CHW-1:0] in_ch,
  input  logic [W-1:0]   in_data,
  output logic           out_vld,
  output logic [CHW-1:0] out_ch,
  output logic [W-1:0]   out_data
);
  localparam int D = (MODE == MODE_COMB) ? M : 1;

  logic [W-1:0] st [NCH][D];
  logic [W-1:0] res;

  // State is read and written in the same cycle, so back-to-back samples
  // on one channel see the freshly updated value without extra forwarding.
  always_comb begin
    res = '0;
    if (MODE == MODE_COMB) res = in_data - st[in_ch][D-1];
    else                   res = st[in_ch][0] + in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld  <= 1'b0;
      out_ch   <= '0;
      out_data <= '0;
      for (int c = 0; c < NCH; c++)
        for (int d = 0; d < D; d++) st[c][d] <= '0;
    end else if (clr) begin
      out_vld  <= 1'b0;
      out_ch   <= '0;
      out_data <= '0;
      for (int c = 0; c < NCH; c++)
        for (int d = 0; d < D; d++) st[c][d] <= '0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_ch   <= in_ch;
        out_data <= res;
        if (MODE == MODE_COMB) begin
          st[in_ch][0] <= in_data;
          for (int d = 1; d < D; d++) st[in_ch][d] <= st[in_ch][d-1];
        end else begin
          st[in_ch][0] <= res;
        end
      end
    end
  end
endmodule

// File: rtl/cic_decim_mc.sv
// Multichannel CIC decimator: shared integrator/comb pipeline, per-channel
// phase counters, runtime power-of-two ratio and gain-normalised output.
module cic_decim_mc
  import cic_decim_mc_pkg::*;
#(
  parameter  int WIN      = 16,
  parameter  int WOUT     = 16,
  parameter  int N        = 3,
  parameter  int M        = 1,
  parameter  int RLOG_MAX = 6,
  parameter  int NCH      = 2,
  localparam int CHW      = (NCH > 1) ? clog2(NCH) : 1,
  localparam int RLW      = clog2(RLOG_MAX + 1),
  localparam int WF       = WIN + cic_wg(N, RLOG_MAX, M)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WIN-1:0]  i_data,
  input  logic [CHW-1:0]  i_ch,
  input  logic            val_in,
  input  logic            cfg_we,
  input  logic [RLW-1:0]  cfg_rlog,
  input  logic            cfg_round,
  output logic            val_out,
  output logic [CHW-1:0]  o_ch,
  output logic [WOUT-1:0] o_data_trunc,
  output logic [WF-1:0]   o_data_full
);
  localparam int CLM = clog2(M);

  logic [RLW-1:0]      rlog, rlog_new;
  logic                rnd;
  logic [RLOG_MAX-1:0] phase [NCH];
  logic [RLOG_MAX-1:0] ph_last;
  logic                ch_ok, acc, last;
  logic [N:0]          dec_pipe;
  logic                s0_vld;
  logic [CHW-1:0]      s0_ch;
  logic [WIN-1:0]      s0_data;

  logic [N:0]                iv, cv;
  logic [N:0][CHW-1:0]       ich, cch;
  logic [N:0][WF-1:0]        idat, cdat;

  if (NCH == (1 << CHW)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (i_ch < CHW'(NCH));
  end

  assign ph_last = RLOG_MAX'((1 << rlog) - 1);
  assign acc     = val_in && !cfg_we && ch_ok;
  assign last    = (phase[i_ch] == ph_last);

  always_comb begin
    rlog_new = cfg_rlog;
    if (cfg_rlog == '0)                    rlog_new = RLW'(1);
    else if (cfg_rlog > RLW'(RLOG_MAX))    rlog_new = RLW'(RLOG_MAX);
  end

  // Input register; dec_pipe[k] marks the sample leaving integrator k as decimating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rlog     <= RLW'(RLOG_MAX);
      rnd      <= 1'b0;
      s0_vld   <= 1'b0;
      s0_ch    <= '0;
      s0_data  <= '0;
      dec_pipe <= '0;
      for (int c = 0; c < NCH; c++) phase[c] <= '0;
    end else if (cfg_we) begin
      rlog     <= rlog_new;
      rnd      <= cfg_round;
      s0_vld   <= 1'b0;
      s0_ch    <= '0;
      s0_data  <= '0;
      dec_pipe <= '0;
      for (int c = 0; c < NCH; c++) phase[c] <= '0;
    end else begin
      s0_vld   <= acc;
      s0_ch    <= i_ch;
      s0_data  <= i_data;
      dec_pipe <= {dec_pipe[N-1:0], acc && last};
      if (acc) phase[i_ch] <= last ? '0 : phase[i_ch] + 1'b1;
    end
  end

  assign iv[0]   = s0_vld;
  assign ich[0]  = s0_ch;
  assign idat[0] = {{(WF-WIN){s0_data[WIN-1]}}, s0_data};
  assign cv[0]   = iv[N] & dec_pipe[N];
  assign cch[0]  = ich[N];
  assign cdat[0] = idat[N];

  for (genvar k = 0; k < N; k++) begin : g_int
    cic_decim_mc_stage #(.MODE(MODE_INT), .W(WF), .NCH(NCH), .M(M), .CHW(CHW)) u_int (
      .clk, .rst, .clr(cfg_we),
      .in_vld(iv[k]), .in_ch(ich[k]), .in_data(idat[k]),
      .out_vld(iv[k+1]), .out_ch(ich[k+1]), .out_data(idat[k+1])
    );
  end

  for (genvar k = 0; k < N; k++) begin : g_comb
    cic_decim_mc_stage #(.MODE(MODE_COMB), .W(WF), .NCH(NCH), .M(M), .CHW(CHW)) u_comb (
      .clk, .rst, .clr(cfg_we),
      .in_vld(cv[k]), .in_ch(cch[k]), .in_data(cdat[k]),
      .out_vld(cv[k+1]), .out_ch(cch[k+1]), .out_data(cdat[k+1])
    );
  end

  int                    sh;
  logic signed [WF:0]    ext, half, rsum, shd;
  logic                  ovf;
  logic [WOUT-1:0]       norm;

  // One guard bit above WF keeps the rounding add from wrapping before saturation.
  always_comb begin
    sh   = N * (int'(rlog) + CLM) + WIN - WOUT;
    ext  = $signed({cdat[N][WF-1], cdat[N]});
    half = rnd ? ((WF+1)'(1) << (sh - 1)) : '0;
    rsum = ext + half;
    shd  = rsum >>> sh;
    ovf  = !((&shd[WF:WOUT-1]) || !(|shd[WF:WOUT-1]));
    norm = shd[WOUT-1:0];
    if (rnd && ovf) norm = shd[WF] ? {1'b1, {(WOUT-1){1'b0}}} : {1'b0, {(WOUT-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_out      <= 1'b0;
      o_ch         <= '0;
      o_data_trunc <= '0;
      o_data_full  <= '0;
    end else if (cfg_we) begin
      val_out      <= 1'b0;
      o_ch         <= '0;
      o_data_trunc <= '0;
      o_data_full  <= '0;
    end else begin
      val_out <= cv[N];
      if (cv[N]) begin
        o_ch         <= cch[N];
        o_data_full  <= cdat[N];
        o_data_trunc <= norm;
      end
    end
  end
endmodule
